// File: rtl/stream_mux_rr.sv
// N-to-1 packet stream multiplexer with a registered output stage.
// A grant is held for a whole packet; mode selects fixed (sel) or round-robin arbitration.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    // Handshake: a beat moves when valid and ready are both high at a rising edge;
    // valid never waits on ready, and ready is only offered to the granted channel.

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);

    state_t            state_q, state_d;
    logic [SELW-1:0]   grant_q, grant_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SELW-1:0]   out_sel_q, out_sel_d;

    logic [WIDTH-1:0]  in_arr [N];
    logic [SELW-1:0]   rr_idx;
    logic [SELW-1:0]   rr_pick;
    logic              rr_found;
    logic              slot_free;
    logic              take;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Search starts one past the last granted channel so every channel gets a turn.
    always_comb begin
        rr_idx   = '0;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            rr_idx = SELW'((int'(ptr_q) + i) % N);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign take      = (state_q == LOCKED) && slot_free && in_valid[grant_q];

    always_comb begin
        in_ready = '0;
        if (state_q == LOCKED && slot_free) begin
            in_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;

        case (state_q)
            IDLE: begin
                if (!mode) begin
                    if (({1'b0, sel} < N_EXT) && in_valid[sel]) begin
                        state_d = LOCKED;
                        grant_d = sel;
                    end
                end else if (rr_found) begin
                    state_d = LOCKED;
                    grant_d = rr_pick;
                end
            end
            LOCKED: begin
                if (take && in_last[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = in_arr[grant_q];
            out_last_d  = in_last[grant_q];
            out_sel_d   = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= SELW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus a randomized run, checked against
// a packet-level reference model and an expected-beat queue.
module tb_stream_mux_rr;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;
    localparam int W     = SELW + 1 + WIDTH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                mode = 1'b0;
    logic [SELW-1:0]     sel = '0;
    logic [N-1:0]        in_valid = '0;
    logic [N*WIDTH-1:0]  in_data = '0;
    logic [N-1:0]        in_last = '0;
    logic [N-1:0]        in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic                out_last;
    logic [SELW-1:0]     out_sel;
    logic                out_ready = 1'b0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0]     exp_q[$];
    logic [WIDTH:0]   src_q[N][$];
    int               pkt_log[$];
    logic [WIDTH-1:0] out_dlog[$];
    bit               pkt_start = 1'b1;

    // Reference model: which channel owns the output (-1 = none), last winner, output occupancy.
    int m_lock = -1;
    int m_ptr  = N - 1;
    bit m_ov   = 1'b0;

    int              en_pct = 100;
    int              ordy_pct = 100;
    bit              rand_ms = 1'b0;
    logic            cur_mode = 1'b0;
    logic [SELW-1:0] cur_sel = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input int ch, input logic [WIDTH-1:0] d, input logic last);
        src_q[ch].push_back({last, d});
    endtask

    task automatic push_pkt(input int ch, input int len);
        for (int b = 0; b < len; b++)
            push_beat(ch, WIDTH'($urandom_range(0, 255)), (b == len - 1));
    endtask

    task automatic reset_model();
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        m_lock    = -1;
        m_ptr     = N - 1;
        m_ov      = 1'b0;
        pkt_start = 1'b1;
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0) || m_ov || (m_lock >= 0);
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bit v = (src_q[k].size() > 0) && ($urandom_range(0, 99) < en_pct);
            in_valid[k] = v;
            if (v) begin
                {in_last[k], in_data[k*WIDTH +: WIDTH]} = src_q[k][0];
            end else begin
                in_last[k] = 1'($urandom_range(0, 1));
                in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            end
        end
        if (rand_ms) begin
            mode = 1'($urandom_range(0, 1));
            sel  = SELW'($urandom_range(0, N - 1));
        end else begin
            mode = cur_mode;
            sel  = cur_sel;
        end
        out_ready = ($urandom_range(0, 99) < ordy_pct);
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_lock >= 0 && (!m_ov || out_ready)) exp_rdy[m_lock] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("out_beat", 32'({out_sel, out_last, out_data}), 32'(exp_q[0]));
        end
        if (out_valid && out_ready) begin
            if (pkt_start) pkt_log.push_back(int'(out_sel));
            pkt_start = out_last;
            out_dlog.push_back(out_data);
        end
    endtask

    // Advance the model across the coming rising edge using the inputs just driven.
    task automatic model_step();
        int acc  = -1;
        int nlck = m_lock;
        int nptr = m_ptr;
        bit nov  = m_ov;
        if (m_ov && out_ready) void'(exp_q.pop_front());
        if (m_lock >= 0 && in_valid[m_lock] && (!m_ov || out_ready)) acc = m_lock;
        if (acc >= 0) begin
            exp_q.push_back({SELW'(acc), in_last[acc], in_data[acc*WIDTH +: WIDTH]});
            void'(src_q[acc].pop_front());
            nov = 1'b1;
            if (in_last[acc]) begin
                nlck = -1;
                nptr = acc;
            end
        end else if (out_ready) begin
            nov = 1'b0;
        end
        if (m_lock < 0) begin
            if (mode == 1'b0) begin
                if (int'(sel) < N && in_valid[sel]) nlck = int'(sel);
            end else begin
                for (int i = 1; i <= N; i++) begin
                    int c = (m_ptr + i) % N;
                    if (in_valid[c]) begin
                        nlck = c;
                        break;
                    end
                end
            end
        end
        m_lock = nlck;
        m_ptr  = nptr;
        m_ov   = nov;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while (busy() && c < budget) begin
            cycle();
            c++;
        end
        check(tag, 32'(busy()), 32'd0);
    endtask

    task automatic wait_lock(input int ch, input bit need_ov);
        int t = 0;
        while (!(m_lock == ch && (m_ov || !need_ov)) && t < 30) begin
            cycle();
            t++;
        end
        check("lock_wait", 32'(m_lock == ch), 32'd1);
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [WIDTH-1:0] seq_exp[3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from reset: channel 0 first, wrapping back to 0.
        cur_mode = 1'b1;
        for (int k = 0; k < N; k++) push_pkt(k, 2);
        push_pkt(0, 2);
        pkt_log.delete();
        drain("drain_rr", 200);
        check("rr_count", 32'(pkt_log.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < pkt_log.size()) check("rr_order", 32'(pkt_log[i]), 32'(rr_exp[i]));

        // Fixed select on channel 2.
        cur_mode = 1'b0;
        cur_sel  = 2'd2;
        push_beat(2, 8'h11, 1'b0);
        push_beat(2, 8'h22, 1'b0);
        push_beat(2, 8'h33, 1'b1);
        out_dlog.delete();
        drain("drain_fixed", 50);
        check("fixed_count", 32'(out_dlog.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < out_dlog.size()) check("fixed_data", 32'(out_dlog[i]), 32'(seq_exp[i]));

        // Downstream stall holds the output beat.
        cur_mode = 1'b1;
        ordy_pct = 0;
        push_beat(1, 8'hA5, 1'b0);
        push_beat(1, 8'h5A, 1'b1);
        out_dlog.delete();
        run(6);
        check("stall_hold", 32'(out_data), 32'hA5);
        check("stall_ready", 32'(in_ready), 32'd0);
        ordy_pct = 100;
        drain("drain_stall", 50);
        check("stall_count", 32'(out_dlog.size()), 32'd2);
        if (out_dlog.size() == 2) check("stall_second", 32'(out_dlog[1]), 32'h5A);

        // Fixed select on an idle channel never grants; switching sel grants next cycle.
        cur_mode = 1'b0;
        cur_sel  = 2'd3;
        push_pkt(1, 2);
        pkt_log.delete();
        run(4);
        check("sel3_no_xfer", 32'(pkt_log.size()), 32'd0);
        cur_sel = 2'd1;
        drain("drain_sel", 50);
        check("sel1_granted", 32'(pkt_log.size()), 32'd1);

        // Mode/sel churn during a locked packet is ignored.
        cur_mode = 1'b1;
        push_pkt(1, 4);
        pkt_log.delete();
        wait_lock(1, 1'b0);
        push_pkt(0, 2);
        rand_ms = 1'b1;
        run(2);
        rand_ms = 1'b0;
        drain("drain_lock", 50);
        check("lock_count", 32'(pkt_log.size()), 32'd2);
        if (pkt_log.size() == 2) begin
            check("lock_first", 32'(pkt_log[0]), 32'd1);
            check("lock_next", 32'(pkt_log[1]), 32'd0);
        end

        // Randomized traffic, back-pressure, mode and sel.
        rand_ms  = 1'b1;
        en_pct   = 70;
        ordy_pct = 70;
        repeat (3000) begin
            for (int k = 0; k < N; k++)
                if (src_q[k].size() < 3 && $urandom_range(0, 9) == 0)
                    push_pkt(k, $urandom_range(1, 5));
            cycle();
        end
        rand_ms  = 1'b0;
        cur_mode = 1'b1;
        en_pct   = 100;
        ordy_pct = 100;
        drain("drain_random", 2000);

        // Asynchronous reset mid-packet on channel 3.
        push_pkt(3, 6);
        wait_lock(3, 1'b1);
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        reset_model();
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pkt_log.delete();
        for (int k = 0; k < N; k++) push_pkt(k, 1);
        drain("drain_after_rst", 100);
        check("arst_count", 32'(pkt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < pkt_log.size()) check("arst_order", 32'(pkt_log[i]), 32'(rr_exp[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
